// File: rtl/fetch_decode_controller.sv
// Fetch/decode controller: walks the program counter through the instruction memory,
// resolves HALT and JUMP locally and hands every other word to the datapath via valid/ready.
module fetch_decode_controller #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned INSTR_W = 12,
    parameter int unsigned IM_LAT  = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               im_loading,
    output logic [ADDR_W-1:0]  IM_add,
    input  logic [INSTR_W-1:0] IM_rd,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [2:0]         opcode,
    input  logic               dp_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int unsigned    LAT_W   = (IM_LAT > 0) ? $clog2(IM_LAT + 1) : 1;
    localparam logic [2:0]     OpJump  = 3'b110;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StDecode,
        StIssue,
        StHalt
    } state_t;

    state_t             state;
    logic [LAT_W-1:0]   wait_cnt;
    logic [INSTR_W-1:0] ir;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= StIdle;
            pc          <= '0;
            IM_add      <= '0;
            instr_out   <= '0;
            opcode      <= '0;
            instr_count <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            wait_cnt    <= '0;
            ir          <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    IM_add <= pc;
                    if (!im_loading && (run || step)) state <= StFetch;
                end
                StFetch: begin
                    if (im_loading) begin
                        state <= StIdle;
                    end else begin
                        IM_add   <= pc;
                        wait_cnt <= LAT_W'(IM_LAT);
                        state    <= StWait;
                    end
                end
                StWait: begin
                    // A loader write may be changing the word under us: abandon this fetch.
                    if (im_loading) begin
                        state <= StIdle;
                    end else if (wait_cnt == '0) begin
                        ir    <= IM_rd;
                        state <= StDecode;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StDecode: begin
                    if (ir == '0) begin
                        halted <= 1'b1;
                        state  <= StHalt;
                    end else if (ir[INSTR_W-1 -: 3] == OpJump) begin
                        pc    <= ir[ADDR_W-1:0];
                        state <= run ? StFetch : StIdle;
                    end else begin
                        instr_out   <= ir;
                        opcode      <= ir[INSTR_W-1 -: 3];
                        instr_valid <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    if (dp_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + 1'b1;
                        if (instr_count != CntMax) instr_count <= instr_count + 1'b1;
                        state <= run ? StFetch : StIdle;
                    end
                end
                StHalt: begin
                    halted      <= 1'b1;
                    instr_valid <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_controller.sv
// Bench for fetch_decode_controller: directed program scenarios plus randomized handshake and
// control traffic compared against a program-order model of the instruction memory.
module tb_fetch_decode_controller;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned INSTR_W = 12;
    localparam int unsigned IM_LAT  = 1;
    localparam int unsigned CNT_W   = 8;

    localparam logic [INSTR_W-1:0] DEF_MEM [8] = '{12'hE01, 12'hE03, 12'hE07, 12'hE0F,
                                                   12'hE1F, 12'hE3F, 12'hE7F, 12'hEFF};

    logic               CLK = 1'b0;
    logic               reset = 1'b1;
    logic               run = 1'b0;
    logic               step = 1'b0;
    logic               im_loading = 1'b0;
    logic               dp_ready = 1'b0;
    logic [ADDR_W-1:0]  IM_add;
    logic [INSTR_W-1:0] IM_rd;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [2:0]         opcode;
    logic [ADDR_W-1:0]  pc;
    logic               halted;
    logic [CNT_W-1:0]   instr_count;

    logic [INSTR_W-1:0] mem [8];
    logic [INSTR_W-1:0] acc_word [$];
    logic [ADDR_W-1:0]  acc_pc [$];
    logic [INSTR_W-1:0] prev_word = '0;
    logic               prev_stall = 1'b0;
    int                 n_tests = 0;
    int                 n_fail = 0;

    fetch_decode_controller #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .IM_LAT (IM_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .im_loading (im_loading),
        .IM_add     (IM_add),
        .IM_rd      (IM_rd),
        .instr_valid(instr_valid),
        .instr_out  (instr_out),
        .opcode     (opcode),
        .dp_ready   (dp_ready),
        .pc         (pc),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 CLK = ~CLK;

    // Registered-read instruction memory, one cycle of latency.
    always @(posedge CLK) IM_rd <= mem[IM_add];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake monitor: logs accepted words, checks the word holds across stalls.
    always @(negedge CLK) begin
        if (!reset && prev_stall && instr_valid)
            check("stall_hold", 32'(instr_out), 32'(prev_word));
        if (!reset && instr_valid && dp_ready) begin
            check("opcode_field", 32'(opcode), 32'(instr_out[11:9]));
            acc_word.push_back(instr_out);
            acc_pc.push_back(pc);
        end
        prev_stall = !reset && instr_valid && !dp_ready;
        prev_word  = instr_out;
    end

    task automatic load_default();
        for (int i = 0; i < 8; i++) mem[i] = DEF_MEM[i];
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        reset = 1'b1; run = 1'b0; step = 1'b0; im_loading = 1'b0; dp_ready = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b0;
        acc_word.delete();
        acc_pc.delete();
    endtask

    // Returns between a negedge and the next posedge once n words have been accepted.
    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_word.size() < n && k < budget) begin
            @(negedge CLK); #2;
            k++;
        end
        if (acc_word.size() < n) check("acc_timeout", 32'(acc_word.size()), 32'(n));
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!instr_valid && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    // Program-order model: follow jumps from p; 0 = issuable word at p, 1 = halt, 2 = jump loop.
    function automatic int resolve(inout logic [ADDR_W-1:0] p);
        for (int k = 0; k < 16; k++) begin
            if (mem[p] == '0) return 1;
            if (mem[p][11:9] != 3'b110) return 0;
            p = mem[p][ADDR_W-1:0];
        end
        return 2;
    endfunction

    initial begin
        int                 lat;
        int                 n;
        int                 r;
        logic [ADDR_W-1:0]  mpc;
        logic [INSTR_W-1:0] w;

        // T1: reset values, fetch latency, program order with wrap, then count saturation.
        load_default();
        do_reset();
        @(negedge CLK);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_instr", 32'(instr_out), 32'd0);
        check("rst_imadd", 32'(IM_add), 32'd0);
        @(posedge CLK); #1;
        run = 1'b1; dp_ready = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge CLK); #1;
            lat++;
            if (instr_valid) break;
        end
        check("fetch_latency", 32'(lat), 32'(IM_LAT + 4));
        wait_acc(9, 200);
        @(posedge CLK); #1;
        dp_ready = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 9; i++) begin
            check("t1_word", 32'(acc_word[i]), 32'(DEF_MEM[i % 8]));
            check("t1_pc", 32'(acc_pc[i]), 32'(i % 8));
        end
        check("t1_count9", 32'(instr_count), 32'd9);
        dp_ready = 1'b1;
        wait_acc(262, 3000);
        @(posedge CLK); #1;
        dp_ready = 1'b0;
        @(negedge CLK);
        check("count_saturate", 32'(instr_count), 32'd255);

        // T2: stall on E07 for five cycles, then a single accept.
        do_reset();
        run = 1'b1; dp_ready = 1'b1;
        wait_acc(2, 100);
        @(posedge CLK); #1;
        dp_ready = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", 32'(instr_valid), 32'd1);
            check("t2_word", 32'(instr_out), 32'hE07);
            check("t2_pc", 32'(pc), 32'd2);
            @(negedge CLK);
        end
        @(posedge CLK); #1;
        dp_ready = 1'b1;
        @(posedge CLK); #1;
        dp_ready = 1'b0;
        @(negedge CLK);
        check("t2_pc_after", 32'(pc), 32'd3);
        check("t2_nacc", 32'(acc_word.size()), 32'd3);
        check("t2_count", 32'(instr_count), 32'd3);

        // T3: jump at address 2 lands on 5.
        load_default();
        mem[2] = 12'hC05;
        do_reset();
        run = 1'b1; dp_ready = 1'b1;
        wait_acc(4, 200);
        @(posedge CLK); #1;
        dp_ready = 1'b0;
        repeat (8) @(negedge CLK);
        check("t3_w2", 32'(acc_word[2]), 32'hE3F);
        check("t3_pc2", 32'(acc_pc[2]), 32'd5);
        check("t3_w3", 32'(acc_word[3]), 32'hE7F);
        check("t3_count", 32'(instr_count), 32'd4);

        // T4: HALT at address 3 is sticky until reset.
        load_default();
        mem[3] = 12'h000;
        do_reset();
        run = 1'b1; dp_ready = 1'b1;
        repeat (60) @(negedge CLK);
        check("t4_nacc", 32'(acc_word.size()), 32'd3);
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_pc", 32'(pc), 32'd3);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1; step = 1'b1;
            @(posedge CLK); #1; step = 1'b0;
        end
        im_loading = 1'b1;
        repeat (20) @(negedge CLK);
        check("t4_nacc_step", 32'(acc_word.size()), 32'd3);
        check("t4_still_halted", 32'(halted), 32'd1);
        check("t4_no_valid", 32'(instr_valid), 32'd0);
        do_reset();
        @(negedge CLK);
        check("t4_rst_halted", 32'(halted), 32'd0);
        check("t4_rst_pc", 32'(pc), 32'd0);

        // T5: single step, with a stray step pulse while waiting for ready.
        load_default();
        do_reset();
        @(posedge CLK); #1; step = 1'b1;
        @(posedge CLK); #1; step = 1'b0;
        wait_valid(20);
        check("t5_word", 32'(instr_out), 32'hE01);
        @(posedge CLK); #1; step = 1'b1;
        @(posedge CLK); #1; step = 1'b0;
        dp_ready = 1'b1;
        repeat (30) @(negedge CLK);
        check("t5_nacc", 32'(acc_word.size()), 32'd1);
        check("t5_pc", 32'(pc), 32'd1);
        check("t5_valid", 32'(instr_valid), 32'd0);

        // T6: loader activity during WAIT at pc=4 aborts the fetch.
        do_reset();
        run = 1'b1; dp_ready = 1'b1;
        wait_acc(4, 200);
        @(posedge CLK);
        @(posedge CLK); #1;
        im_loading = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t6_valid", 32'(instr_valid), 32'd0);
            check("t6_pc", 32'(pc), 32'd4);
            check("t6_imadd", 32'(IM_add), 32'd4);
        end
        @(posedge CLK); #1;
        im_loading = 1'b0;
        wait_acc(5, 50);
        check("t6_word", 32'(acc_word[4]), 32'hE1F);
        check("t6_accpc", 32'(acc_pc[4]), 32'd4);
        check("t6_nacc", 32'(acc_word.size()), 32'd5);
        dp_ready = 1'b0;

        // Randomized programs and control traffic versus the program-order model.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) begin
                r = $urandom_range(0, 15);
                if (r == 0) begin
                    w = '0;
                end else if (r <= 2) begin
                    w = {3'b110, 9'($urandom_range(0, 511))};
                end else begin
                    do w = 12'($urandom_range(1, 4095)); while (w[11:9] == 3'b110);
                end
                mem[i] = w;
            end
            do_reset();
            for (int c = 0; c < 400; c++) begin
                @(posedge CLK); #1;
                dp_ready   = $urandom_range(0, 2) != 0;
                run        = $urandom_range(0, 3) != 0;
                step       = $urandom_range(0, 7) == 0;
                im_loading = $urandom_range(0, 9) == 0;
            end
            @(posedge CLK); #1;
            run = 1'b1; dp_ready = 1'b1; step = 1'b0; im_loading = 1'b0;
            repeat (80) @(negedge CLK);
            @(posedge CLK); #1;
            run = 1'b0; dp_ready = 1'b0;
            repeat (3) @(negedge CLK);
            n = acc_word.size();
            mpc = '0;
            for (int k = 0; k < n; k++) begin
                r = resolve(mpc);
                if (r != 0) begin
                    check("rand_extra_issue", 32'(k), 32'(n));
                    break;
                end
                check("rand_word", 32'(acc_word[k]), 32'(mem[mpc]));
                check("rand_pc", 32'(acc_pc[k]), 32'(mpc));
                mpc = mpc + 1'b1;
            end
            r = resolve(mpc);
            check("rand_halted", 32'(halted), (r == 1) ? 32'd1 : 32'd0);
            check("rand_count", 32'(instr_count), (n > 255) ? 32'd255 : 32'(n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
